keypad_encoder: RTL and testbench

KEYPAD_ENCODER -- requirements
Module: keypad_encoder

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_encoder_sync2.sv | 30 +++
 rtl/keypad_encoder.sv | 119 +++++++++++
 tb/tb_keypad_encoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared FSM state type, key map and helpers for the 4x4 keypad
//               encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Indexed as KEYMAP[row][col]; the first nibble of the concatenation is [0][0].
    localparam logic [0:3][0:3][3:0] KEYMAP = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        logic [1:0] idx;
        idx = 2'd3;
        if (!r[2]) idx = 2'd2;
        if (!r[1]) idx = 2'd1;
        if (!r[0]) idx = 2'd0;
        return idx;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_encoder_sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer with a configurable reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            o_q    <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            o_q    <= r_meta;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : keypad_encoder
// Description : 4x4 matrix keypad scanner with press/release debounce and
//               single-key (no rollover) hex encoding.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4800,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] c_scan_last = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] c_deb_last  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] c_one       = CW'(1);

    logic [3:0]    w_rows_s;
    state_t        r_state;
    logic [1:0]    r_col;
    logic [1:0]    r_row;
    logic [CW-1:0] r_cnt;
    logic          w_row_low;
    logic [1:0]    w_next_col;

    sync2 #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rows),
        .o_q   (w_rows_s)
    );

    assign w_row_low  = ~w_rows_s[r_row];
    assign w_next_col = r_col + 2'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_SCAN;
            r_col     <= 2'd0;
            r_row     <= 2'd0;
            r_cnt     <= '0;
            cols      <= 4'b1110;
            key       <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    // Sampling waits until the synchronizer has seen the current column.
                    if (r_cnt == c_scan_last) begin
                        r_cnt <= '0;
                        if (w_rows_s != 4'b1111) begin
                            r_row   <= lowest_low(w_rows_s);
                            r_state <= ST_DEBOUNCE;
                        end else begin
                            r_col <= w_next_col;
                            cols  <= col_drive(w_next_col);
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!w_row_low) begin
                        r_state <= ST_SCAN;
                        r_cnt   <= '0;
                        r_col   <= w_next_col;
                        cols    <= col_drive(w_next_col);
                    end else if (r_cnt == c_deb_last) begin
                        key       <= KEYMAP[r_row][r_col];
                        key_valid <= 1'b1;
                        r_state   <= ST_HELD;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                ST_HELD: begin
                    if (!w_row_low) begin
                        r_state <= ST_RELEASE;
                        r_cnt   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (w_row_low) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_deb_last) begin
                        r_state <= ST_SCAN;
                        r_cnt   <= '0;
                        r_col   <= w_next_col;
                        cols    <= col_drive(w_next_col);
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_encoder
// Description : Randomized scoreboard bench for keypad_encoder with a keypad
//               matrix model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;

    logic [15:0] pressed = '0;
    logic [3:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;

    keypad_encoder #(
        .SCAN_CYCLES     (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    // A pressed switch shorts its row to its column only while that column is driven low.
    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
    end

    function automatic logic [3:0] ref_key(input int r, input int c);
        string km;
        byte   ch;
        km = "123A456B789CE0FD";
        ch = km[r*4+c];
        if (ch <= 8'd57) return 4'(ch - 8'd48);
        return 4'(ch - 8'd55);
    endfunction

    function automatic logic [3:0] ref_cols(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << (c % 4));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got key %0h expected no pulse", key);
            end else begin
                check("key_on_pulse", {28'd0, key}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r*4+c] = v;
    endtask

    task automatic wait_pulse(input int base, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (pulses > base) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic press_key(input int r, input int c, input int bl, input int bh,
                             input bit chatter, input int hold);
        int         base;
        int         bad;
        bit         ok;
        logic [3:0] held;
        base = pulses;
        bad  = 0;
        held = ref_cols(c);
        exp_q.push_back(ref_key(r, c));
        if (bl > 0) begin
            set_key(r, c, 1'b1);
            tick(bl);
            set_key(r, c, 1'b0);
            tick(bh);
        end
        set_key(r, c, 1'b1);
        wait_pulse(base, 200, ok);
        check("press_accepted", {31'd0, ok}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (cols !== held) bad++;
            tick(1);
        end
        check("cols_frozen_held", bad, 0);
        set_key(r, c, 1'b0);
        if (chatter) begin
            tick(3);
            set_key(r, c, 1'b1);
            tick(1);
            set_key(r, c, 1'b0);
        end
        tick(4);
        check("cols_held_in_release", {28'd0, cols}, {28'd0, held});
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cols !== held) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("scan_resumes", {31'd0, ok}, 32'd1);
        check("scan_next_col", {28'd0, cols}, {28'd0, ref_cols(c + 1)});
        check("key_holds", {28'd0, key}, {28'd0, ref_key(r, c)});
        check("pulse_count", pulses - base, 1);
        tick(20);
    endtask

    initial begin
        int base;
        bit ok;
        tick(3);
        reset = 1'b0;

        // Idle scan after reset: each column is driven for four cycles in turn.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("idle_cols", {28'd0, cols}, {28'd0, ref_cols(n / 4)});
        end
        check("reset_key", {28'd0, key}, 32'd0);
        check("reset_key_valid", {31'd0, key_valid}, 32'd0);

        press_key(1, 2, 0, 0, 1'b0, 30);
        press_key(3, 1, 1, 1, 1'b1, 5);

        // Second key on the same column while the first is held must be ignored.
        base = pulses;
        exp_q.push_back(ref_key(0, 0));
        set_key(0, 0, 1'b1);
        wait_pulse(base, 200, ok);
        check("rollover_first_accepted", {31'd0, ok}, 32'd1);
        set_key(2, 0, 1'b1);
        tick(10);
        check("rollover_cols_frozen", {28'd0, cols}, {28'd0, ref_cols(0)});
        set_key(0, 0, 1'b0);
        set_key(2, 0, 1'b0);
        tick(40);
        check("rollover_single_pulse", pulses - base, 1);
        check("rollover_key", {28'd0, key}, {28'd0, ref_key(0, 0)});
        press_key(0, 3, 0, 0, 1'b0, 3);

        for (int i = 0; i < 12; i++) begin
            int r, c, bl, bh;
            r  = $urandom_range(3, 0);
            c  = $urandom_range(3, 0);
            bl = $urandom_range(3, 0);
            bh = $urandom_range(2, 1);
            press_key(r, c, bl, bh, 1'($urandom_range(1, 0)), $urandom_range(20, 0));
        end

        // Reset in the middle of debouncing key 9 must abort it silently.
        press_key(0, 3, 0, 0, 1'b0, 2);
        base = pulses;
        set_key(2, 2, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (cols === 4'b1011) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("key9_column_reached", {31'd0, ok}, 32'd1);
        tick(6);
        reset = 1'b1;
        tick(1);
        check("midreset_cols", {28'd0, cols}, 32'hE);
        check("midreset_key", {28'd0, key}, 32'd0);
        check("midreset_key_valid", {31'd0, key_valid}, 32'd0);
        set_key(2, 2, 1'b0);
        tick(2);
        reset = 1'b0;
        tick(40);
        check("midreset_no_pulse", pulses - base, 0);
        check("midreset_key_after", {28'd0, key}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
